// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the word-serial multi-word adder.
package multiword_add_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mwa_state_t;

    // Width of the word index counter; at least one bit even for a single word.
    function automatic int unsigned idx_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_seq_nbitfulladder.sv
// Plain N-bit ripple adder with carry in/out; the shared datapath slice.
module NBitFullAdder #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/multiword_add_seq.sv
// Word-serial add/subtract of W*WORDS-bit operands through one W-bit adder, LSW first,
// with valid/ready handshakes on the command and result sides.
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [W*WORDS-1:0] a_in,
    input  logic [W*WORDS-1:0] b_in,
    input  logic               cin,
    input  logic               sub,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W*WORDS-1:0] sum_out,
    output logic               cout_out,
    output logic               ovf_out
);

    localparam int unsigned TW    = W * WORDS;
    localparam int unsigned IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    mwa_state_t     state_q;
    logic [TW-1:0]  a_q;
    logic [TW-1:0]  b_q;
    logic [IDX_W-1:0] idx_q;
    logic           carry_q;

    logic [W-1:0]   a_word;
    logic [W-1:0]   b_word;
    logic [W-1:0]   s_word;
    logic           c_word;

    assign a_word = a_q[idx_q*W +: W];
    assign b_word = b_q[idx_q*W +: W];

    NBitFullAdder #(
        .N (W)
    ) u_adder (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry_q),
        .sum  (s_word),
        .cout (c_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_ready <= 1'b1;
            res_valid   <= 1'b0;
            sum_out     <= '0;
            cout_out    <= 1'b0;
            ovf_out     <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_valid) begin
                        // Subtraction is A + ~B + 1, so B is stored pre-inverted.
                        a_q         <= a_in;
                        b_q         <= sub ? ~b_in : b_in;
                        carry_q     <= sub ? 1'b1 : cin;
                        idx_q       <= '0;
                        start_ready <= 1'b0;
                        state_q     <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_out[idx_q*W +: W] <= s_word;
                    carry_q               <= c_word;
                    if (idx_q == LAST_IDX) begin
                        cout_out  <= c_word;
                        ovf_out   <= (a_word[W-1] == b_word[W-1]) && (s_word[W-1] != a_word[W-1]);
                        res_valid <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        start_ready <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Randomised and directed bench for multiword_add_seq against a whole-width arithmetic model.
module tb_multiword_add_seq;

    localparam int unsigned W     = 4;
    localparam int unsigned WORDS = 4;
    localparam int unsigned TW    = W * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [TW-1:0] a_in;
    logic [TW-1:0] b_in;
    logic          cin;
    logic          sub;
    logic          res_valid;
    logic          res_ready;
    logic [TW-1:0] sum_out;
    logic          cout_out;
    logic          ovf_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multiword_add_seq #(
        .W     (W),
        .WORDS (WORDS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum_out     (sum_out),
        .cout_out    (cout_out),
        .ovf_out     (ovf_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} for the whole-width operation.
    function automatic logic [TW+1:0] model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                            input logic c, input logic s);
        logic [TW-1:0] bb;
        logic [TW:0]   full;
        logic          ov;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{TW{1'b0}}, (s ? 1'b1 : c)};
        ov   = (a[TW-1] == bb[TW-1]) && (full[TW-1] != a[TW-1]);
        return {ov, full[TW], full[TW-1:0]};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_start_ready"}, start_ready, 1);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_sum"}, sum_out, 0);
        check({tag, "_cout"}, cout_out, 0);
        check({tag, "_ovf"}, ovf_out, 0);
    endtask

    task automatic run_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c,
                          input logic s, input int stall, input bit poke, input bit chk_lat);
        logic [TW+1:0] exp;
        int cnt;
        exp = model(a, b, c, s);
        check("idle_ready", start_ready, 1);
        a_in = a; b_in = b; cin = c; sub = s; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a_in = TW'($urandom); b_in = TW'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        check("busy_ready", start_ready, 0);
        cnt = 0;
        while (!res_valid && cnt < 4 * WORDS) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("res_valid_seen", res_valid, 1);
        if (chk_lat) check("latency", cnt, WORDS);
        check("sum", sum_out, exp[TW-1:0]);
        check("cout", cout_out, exp[TW]);
        check("ovf", ovf_out, exp[TW+1]);
        for (int i = 0; i < stall; i++) begin
            if (poke && i == 1) start_valid = 1'b1;
            @(posedge clk); #1;
            start_valid = 1'b0;
            check("stall_valid", res_valid, 1);
            check("stall_ready", start_ready, 0);
            check("stall_sum", sum_out, exp[TW-1:0]);
            check("stall_flags", {ovf_out, cout_out}, exp[TW+1:TW]);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("release_valid", res_valid, 0);
        check("release_ready", start_ready, 1);
    endtask

    initial begin
        bit pulsed;
        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
        a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_values("reset");

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, 1'b1);

        // Stall in DONE with an ignored command pulse, then a fresh command.
        run_op(16'h1357, 16'h2468, 1'b1, 1'b0, 5, 1'b1, 1'b1);
        @(posedge clk); #1;
        check("no_spurious_accept", start_ready, 1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Abort after two RUN cycles.
        a_in = 16'h1234; b_in = 16'h1111; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("abort");
        pulsed = 1'b0;
        repeat (WORDS + 2) begin
            @(posedge clk); #1;
            if (res_valid) pulsed = 1'b1;
        end
        check("abort_no_pulse", pulsed, 0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("rerun_sum", sum_out, 16'h2345);

        for (int i = 0; i < 2000; i++) begin
            run_op(TW'($urandom), TW'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
